// File: rtl/minibit_sequencer_if.sv
// Request, datapath-feedback and bus-control signals between a requester, the ALU datapath and the sequencer.
// Sequencer side uses the slave modport; the requester/datapath side uses the master modport.
interface minibit_sequencer_if;
  logic       start;
  logic       reuse_a;
  logic [7:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] alu_o;
  logic       pre_carry;
  logic       pre_lt;
  logic       pre_z;
  logic [7:0] bus_out;
  logic       write_bus;
  logic       a_r_n;
  logic       b_r_n;
  logic       a_bus_n;
  logic       b_bus_n;
  logic       fl_carry;
  logic       fl_lt;
  logic       fl_z;
  logic [7:0] result;
  logic       busy;
  logic       done;

  modport slave (
    input  start, reuse_a, opcode, operand_a, operand_b, alu_o, pre_carry, pre_lt, pre_z,
    output bus_out, write_bus, a_r_n, b_r_n, a_bus_n, b_bus_n, fl_carry, fl_lt, fl_z,
           result, busy, done
  );

  modport master (
    output start, reuse_a, opcode, operand_a, operand_b, alu_o, pre_carry, pre_lt, pre_z,
    input  bus_out, write_bus, a_r_n, b_r_n, a_bus_n, b_bus_n, fl_carry, fl_lt, fl_z,
           result, busy, done
  );
endinterface

// File: rtl/minibit_sequencer.sv
// Moore sequencer: loads A (optional) and B over the shared bus, holds the opcode EXEC_CYCLES+1 cycles, captures result/flags.
// Latency start->done is 3+EXEC_CYCLES edges (2+EXEC_CYCLES with reuse_a); start is ignored while busy.
module minibit_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  minibit_sequencer_if.slave  sif
);
  typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, WB} state_t;

  localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_exec_cnt;
  logic [7:0] r_opcode;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_result;
  logic       r_carry;
  logic       r_lt;
  logic       r_z;
  logic       r_done;

  logic       w_accept;
  logic       w_exec_last;
  logic       w_write_bus;
  logic [7:0] w_bus;
  logic       w_a_r_n;
  logic       w_b_r_n;

  assign w_accept    = (r_state == IDLE) && sif.start;
  assign w_exec_last = (r_exec_cnt == EXEC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bus and strobes depend on the registered state and captured operands only.
  always_comb begin
    w_next      = r_state;
    w_write_bus = 1'b0;
    w_bus       = 8'h00;
    w_a_r_n     = 1'b1;
    w_b_r_n     = 1'b1;
    case (r_state)
      IDLE: begin
        if (sif.start) begin
          w_next = sif.reuse_a ? LD_B : LD_A;
        end
      end
      LD_A: begin
        w_write_bus = 1'b1;
        w_bus       = r_a;
        w_a_r_n     = 1'b0;
        w_next      = LD_B;
      end
      LD_B: begin
        w_write_bus = 1'b1;
        w_bus       = r_b;
        w_b_r_n     = 1'b0;
        w_next      = EXEC;
      end
      EXEC: begin
        w_write_bus = 1'b1;
        w_bus       = r_opcode;
        if (w_exec_last) begin
          w_next = WB;
        end
      end
      WB: begin
        w_write_bus = 1'b1;
        w_bus       = r_opcode;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_cnt <= 2'd0;
      r_opcode   <= 8'h00;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_result   <= 8'h00;
      r_carry    <= 1'b0;
      r_lt       <= 1'b0;
      r_z        <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opcode <= sif.opcode;
        r_a      <= sif.operand_a;
        r_b      <= sif.operand_b;
      end
      if (r_state == EXEC && !w_exec_last) begin
        r_exec_cnt <= r_exec_cnt + 2'd1;
      end else begin
        r_exec_cnt <= 2'd0;
      end
      // Result and flags move only on the edge leaving WB.
      if (r_state == WB) begin
        r_result <= sif.alu_o;
        r_carry  <= sif.pre_carry;
        r_lt     <= sif.pre_lt;
        r_z      <= sif.pre_z;
      end
      r_done <= (r_state == WB);
    end
  end

  assign sif.bus_out   = w_bus;
  assign sif.write_bus = w_write_bus;
  assign sif.a_r_n     = w_a_r_n;
  assign sif.b_r_n     = w_b_r_n;
  assign sif.a_bus_n   = 1'b1;
  assign sif.b_bus_n   = 1'b1;
  assign sif.fl_carry  = r_carry;
  assign sif.fl_lt     = r_lt;
  assign sif.fl_z      = r_z;
  assign sif.result    = r_result;
  assign sif.busy      = (r_state != IDLE);
  assign sif.done      = r_done;
endmodule
